outport_vc_credit_arbiter: RTL
==============================

Name: outport_vc_credit_arbiter

Overview:
- Sender-side controller for one router output port.
- Keeps a credit counter per downstream input-port VC. Counters decrement on each grant and increment on each returned credit (the downstream input port's lcrd_v/lcrd_id).
- Arbitrates among REQ_NUM requesters (input ports of this router) round-robin, granting at most one flit per cycle whose target VC has credit.
- Drives the registered transmit valid, VC id and source index toward the downstream router's rx side.

Parameters:
- REQ_NUM, 5, number of requesting input ports.
- VC_NUM, 4, number of downstream VCs.
- VC_DEPTH, 2, buffer depth per downstream VC; also the initial credit count.
- VC_NUM_IDX_W, (VC_NUM>1 ? $clog2(VC_NUM) : 1), VC index width.
- REQ_IDX_W, (REQ_NUM>1 ? $clog2(REQ_NUM) : 1), requester index width.
- CRD_W, $clog2(VC_DEPTH+1), credit counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- req_v_i  in  REQ_NUM  per-requester flit request.
- req_vc_id_i  in  REQ_NUM*VC_NUM_IDX_W  target downstream VC per requester.
- gnt_o  out  REQ_NUM  one-hot grant, same cycle; used as the SA-stage pop.
- gnt_v_o  out  1  OR of gnt_o.
- gnt_idx_o  out  REQ_IDX_W  index of the granted requester.
- lcrd_v_i  in  1  credit return valid.
- lcrd_id_i  in  VC_ID_NUM_MAX_W  VC id of the returned credit.
- tx_flit_v_o  out  1  registered flit valid to the downstream router.
- tx_vc_id_o  out  VC_NUM_IDX_W  registered VC id of the sent flit.
- tx_src_idx_o  out  REQ_IDX_W  registered source requester index; the switch-traversal mux select.
- credit_avail_o  out  VC_NUM  per-VC credit != 0 (registered state).
- credit_err_o  out  1  sticky error: credit overflow or illegal lcrd_id.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - all credit counters = VC_DEPTH;
  - rr_ptr = 0;
  - tx_flit_v_o = 0, tx_vc_id_o = 0, tx_src_idx_o = 0;
  - credit_err_o = 0;
  - credit_avail_o = all ones.
  - gnt_o is forced to 0 while rstn = 0.
- Eligibility (combinational): elig[i] = req_v_i[i] && credit[req_vc_id_i[i]] != 0. Credit is taken from the registered counter only; a credit returned in cycle t is usable at t+1 (no bypass).
- Arbitration:
  - Round-robin search starting at rr_ptr, ascending with wrap; the first eligible requester wins.
  - gnt_o is one-hot or zero. gnt_idx_o = winner index, or 0 when there is no grant.
- rr_ptr update: on a grant, rr_ptr <= (winner+1) mod REQ_NUM, with explicit wrap for non-power-of-2 REQ_NUM. Without a grant, rr_ptr holds.
- Counter update, per VC v:
  - next = cnt - (grant && vc==v) + (lcrd_v_i && lcrd_id_i==v).
  - A grant and a return on the same VC in the same cycle leave the count unchanged.
  - Underflow is impossible by construction (grant requires cnt != 0).
- Overflow: a return when cnt == VC_DEPTH with no simultaneous consume on that VC saturates the count at VC_DEPTH and sets credit_err_o.
- Illegal return: lcrd_v_i with lcrd_id_i >= VC_NUM is ignored and sets credit_err_o. credit_err_o clears only on reset.
- Transmit register: on every clk edge,
  - tx_flit_v_o <= gnt_v_o;
  - tx_vc_id_o <= req_vc_id_i[winner];
  - tx_src_idx_o <= winner.
  - Grant-to-tx latency is exactly 1 cycle.
  - When there is no grant, tx_vc_id_o and tx_src_idx_o hold their previous values.
- A requester must hold req_v_i/req_vc_id_i stable until granted. Request contents are not checked beyond this.
- Back-to-back: one grant per cycle maximum. A VC with credit c accepts at most c grants before a return arrives.
- Reset mid-operation discards any in-flight tx flit and restores all credits. The downstream router is required to reset in the same cycle.
- Non-synthesis only: assertions that gnt_o is onehot0 and that no credit counter exceeds VC_DEPTH.

Decomposition:
- Shared package rvh_noc_pkg: VC_ID_NUM_MAX_W (existing), plus a new credit-counter typedef sized from the max VC depth.
- One sub-module: rr_arbiter_onehot (REQ_NUM-wide round-robin with a pointer input and one-hot/index outputs). It is reusable by the VC allocator.
- The credit counters stay in this block.

Test Plan:
- Reset check: after reset with no traffic, credit_avail_o = 4'b1111; req_v_i=0 for 10 cycles -> gnt_o=0, tx_flit_v_o=0, credit_err_o=0.
- Round-robin: req_v_i=5'b11111, all VC 0, VC_DEPTH=8, returns held off -> grants in order 0,1,2,3,4,0…. tx_src_idx_o follows one cycle later.
- Credit exhaustion: VC_DEPTH=2, requester 1 continuously on VC 2 -> exactly 2 grants. credit_avail_o[2]=0, and gnt_o stays 0 until a return. A return on VC 2 at cycle t -> grant at t+1.
- Simultaneous events: grant on VC 3 plus lcrd_id=3 in the same cycle with credit 1 -> count stays 1. The next cycle grants again.
- Errors: a return on a full VC 0 -> count stays 2, credit_err_o=1. lcrd_id_i=7 with VC_NUM=4 -> ignored, credit_err_o=1.
- Reset mid-operation: all VC credits at 0, assert rstn=0 for one cycle -> counters=VC_DEPTH, rr_ptr=0, tx_flit_v_o=0, credit_err_o=0.

Source files
------------

// File: rtl/rvh_noc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rvh_noc_pkg                                                 |
// | Desc   : Shared NoC widths and types for the router slice.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package rvh_noc_pkg;

  // Width of any VC id carried on a link. It is wide enough to encode ids
  // beyond the VCs actually present, so illegal ids can be detected.
  localparam int VC_ID_NUM_MAX_W = 3;

  // Deepest per-VC buffer supported anywhere in the fabric.
  localparam int VC_DEPTH_MAX = 8;
  localparam int CRD_CNT_W    = $clog2(VC_DEPTH_MAX + 1);

  // Credit counter able to hold 0..VC_DEPTH_MAX.
  typedef logic [CRD_CNT_W-1:0] crd_cnt_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_arbiter_onehot                                           |
// | Desc   : N-way round-robin pick. The search starts at ptr_i and      |
// |          walks upward with wrap; the first set request wins.         |
// |          Produces one-hot grant, grant-valid and winner index.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rr_arbiter_onehot #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_v_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0]     w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;

  // Walk every offset from the pointer; wrap explicitly so non-power-of-2 N works.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!w_found && req_i[w_pos]) begin
        w_found      = 1'b1;
        w_gnt[w_pos] = 1'b1;
        w_idx        = w_pos;
      end
    end
  end

  assign gnt_o   = w_gnt;
  assign gnt_v_o = w_found;
  assign idx_o   = w_idx;

endmodule
`default_nettype wire

// File: rtl/outport_vc_credit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : outport_vc_credit_arbiter                                   |
// | Desc   : Sender side of one router output port. Tracks credits per   |
// |          downstream VC, picks one eligible requester per cycle       |
// |          round-robin and registers the transmit valid/VC/source.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module outport_vc_credit_arbiter
  import rvh_noc_pkg::*;
#(
  parameter int REQ_NUM      = 5,
  parameter int VC_NUM       = 4,
  parameter int VC_DEPTH     = 2,
  parameter int VC_NUM_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int REQ_IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  parameter int CRD_W        = $clog2(VC_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [REQ_NUM-1:0]                req_v_i,
  input  logic [REQ_NUM*VC_NUM_IDX_W-1:0]   req_vc_id_i,
  output logic [REQ_NUM-1:0]                gnt_o,
  output logic                              gnt_v_o,
  output logic [REQ_IDX_W-1:0]              gnt_idx_o,
  input  logic                              lcrd_v_i,
  input  logic [VC_ID_NUM_MAX_W-1:0]        lcrd_id_i,
  output logic                              tx_flit_v_o,
  output logic [VC_NUM_IDX_W-1:0]           tx_vc_id_o,
  output logic [REQ_IDX_W-1:0]              tx_src_idx_o,
  output logic [VC_NUM-1:0]                 credit_avail_o,
  output logic                              credit_err_o
);

  localparam logic [CRD_W-1:0] C_FULL = CRD_W'(VC_DEPTH);

  logic [CRD_W-1:0]        r_cnt [VC_NUM];
  logic [REQ_IDX_W-1:0]    r_rr_ptr;
  logic                    r_tx_v;
  logic [VC_NUM_IDX_W-1:0] r_tx_vc;
  logic [REQ_IDX_W-1:0]    r_tx_src;
  logic                    r_err;

  logic [VC_NUM_IDX_W-1:0] w_req_vc [REQ_NUM];
  logic [VC_NUM-1:0]       w_avail;
  logic [REQ_NUM-1:0]      w_elig;
  logic [REQ_NUM-1:0]      w_gnt;
  logic                    w_gnt_v;
  logic [REQ_IDX_W-1:0]    w_gnt_idx;
  logic [VC_NUM_IDX_W-1:0] w_win_vc;
  logic                    w_lcrd_legal;
  logic                    w_lcrd_illegal;
  logic [VC_NUM-1:0]       w_dec;
  logic [VC_NUM-1:0]       w_inc;
  logic [VC_NUM-1:0]       w_ovf;

  // Split the packed per-requester VC ids and decide who may compete.
  // Eligibility uses only the registered counters: a returned credit is
  // not usable until the cycle after it arrives.
  for (genvar i = 0; i < REQ_NUM; i++) begin : g_req
    assign w_req_vc[i] = req_vc_id_i[i*VC_NUM_IDX_W +: VC_NUM_IDX_W];
    assign w_elig[i]   = rstn && req_v_i[i] && w_avail[w_req_vc[i]];
  end

  rr_arbiter_onehot #(
    .N     (REQ_NUM),
    .IDX_W (REQ_IDX_W)
  ) u_rr (
    .req_i   (w_elig),
    .ptr_i   (r_rr_ptr),
    .gnt_o   (w_gnt),
    .gnt_v_o (w_gnt_v),
    .idx_o   (w_gnt_idx)
  );

  assign w_win_vc       = w_req_vc[w_gnt_idx];
  assign w_lcrd_legal   = lcrd_v_i && (32'(lcrd_id_i) < VC_NUM);
  assign w_lcrd_illegal = lcrd_v_i && !w_lcrd_legal;

  // Per-VC consume/return decode and counter. A return into a full
  // counter with no matching consume saturates and flags an error.
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign w_avail[v] = (r_cnt[v] != '0);
    assign w_dec[v]   = w_gnt_v && (w_win_vc == VC_NUM_IDX_W'(v));
    assign w_inc[v]   = w_lcrd_legal && (lcrd_id_i == VC_ID_NUM_MAX_W'(v));
    assign w_ovf[v]   = w_inc[v] && !w_dec[v] && (r_cnt[v] == C_FULL);

    // Credit counter: restore to full on reset, otherwise net of consume/return.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_cnt[v] <= C_FULL;
      end else if (w_dec[v] && !w_inc[v]) begin
        r_cnt[v] <= r_cnt[v] - CRD_W'(1);
      end else if (w_inc[v] && !w_dec[v] && !w_ovf[v]) begin
        r_cnt[v] <= r_cnt[v] + CRD_W'(1);
      end
    end
  end

  // Advance the round-robin pointer past the winner, wrapping at REQ_NUM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_v) begin
      r_rr_ptr <= (w_gnt_idx == REQ_IDX_W'(REQ_NUM - 1)) ? '0
                                                          : w_gnt_idx + REQ_IDX_W'(1);
    end
  end

  // Transmit register; VC and source hold when nothing is sent.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_v   <= 1'b0;
      r_tx_vc  <= '0;
      r_tx_src <= '0;
    end else begin
      r_tx_v <= w_gnt_v;
      if (w_gnt_v) begin
        r_tx_vc  <= w_win_vc;
        r_tx_src <= w_gnt_idx;
      end
    end
  end

  // Sticky credit error: overflow on any VC or an out-of-range return id.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if ((|w_ovf) || w_lcrd_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign gnt_o          = w_gnt;
  assign gnt_v_o        = w_gnt_v;
  assign gnt_idx_o      = w_gnt_idx;
  assign tx_flit_v_o    = r_tx_v;
  assign tx_vc_id_o     = r_tx_vc;
  assign tx_src_idx_o   = r_tx_src;
  assign credit_avail_o = w_avail;
  assign credit_err_o   = r_err;

`ifndef SYNTHESIS
  // Grant must be one-hot or empty and no counter may exceed the buffer depth.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert ($onehot0(gnt_o));
      for (int v = 0; v < VC_NUM; v++) begin
        assert (r_cnt[v] <= C_FULL);
      end
    end
  end
`endif

endmodule
`default_nettype wire
